io_responder: RTL and testbench

Memory-mapped I/O responder on the CPU's data-memory port, the target end of the CPU load/store interface. It decodes a 4-byte address window and answers CPU reads and writes with a synchronous-read timing identical to data memory. Behind the window sit a TX FIFO, drained to an external sink over valid/ready, and an RX FIFO, filled by an external source over valid/ready.

---
 rtl/io_responder_if.sv | 31 +++
 rtl/io_responder.sv | 156 +++++++++++++++
 tb/tb_io_responder.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/io_responder_if.sv
// CPU data-memory port plus TX/RX valid/ready streams of io_responder,
// bundled so the responder and its environment see one connection.
interface io_responder_if #(
    parameter int DataWidth = 8,
    parameter int AddrWidth = 8
);
    logic                 Mem_En;
    logic                 Write_EN;
    logic [AddrWidth-1:0] Address;
    logic [DataWidth-1:0] DIn;
    logic [DataWidth-1:0] DOut;
    logic                 Hit;
    logic [DataWidth-1:0] Tx_Data;
    logic                 Tx_Valid;
    logic                 Tx_Ready;
    logic [DataWidth-1:0] Rx_Data;
    logic                 Rx_Valid;
    logic                 Rx_Ready;

    // Environment side: CPU, TX sink and RX source.
    modport master (
        output Mem_En, Write_EN, Address, DIn, Tx_Ready, Rx_Data, Rx_Valid,
        input  DOut, Hit, Tx_Data, Tx_Valid, Rx_Ready
    );

    // Responder side.
    modport slave (
        input  Mem_En, Write_EN, Address, DIn, Tx_Ready, Rx_Data, Rx_Valid,
        output DOut, Hit, Tx_Data, Tx_Valid, Rx_Ready
    );
endinterface

// File: rtl/io_responder.sv
// Memory-mapped I/O responder: 4-register window (DATA/STATUS/CTRL/reserved)
// over a TX and an RX FIFO. Optional interrupt output under IO_RESPONDER_IRQ_EN.
module io_responder #(
    parameter int                   DataWidth     = 8,
    parameter int                   AddrWidth     = 8,
    parameter logic [AddrWidth-1:0] BaseAddr      = 'hF0,
    parameter int                   FifoDepthLog2 = 2
) (
    input  logic Clk,
    input  logic Reset,
    io_responder_if.slave bus
`ifdef IO_RESPONDER_IRQ_EN
    ,
    output logic Irq
`endif
);

    localparam int Depth = 1 << FifoDepthLog2;
    localparam int PtrW  = FifoDepthLog2 + 1;

    typedef enum logic [1:0] {
        OFF_DATA   = 2'd0,
        OFF_STATUS = 2'd1,
        OFF_CTRL   = 2'd2,
        OFF_RSVD   = 2'd3
    } reg_off_e;

    logic [PtrW-1:0]      tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [PtrW-1:0]      rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [DataWidth-1:0] tx_mem_q [Depth];
    logic [DataWidth-1:0] rx_mem_q [Depth];
    logic                 tx_drop_q, tx_drop_d, rx_under_q, rx_under_d;
    logic [DataWidth-1:0] dout_q, dout_d;

    logic                 access, cpu_wr, cpu_rd;
    reg_off_e             offset;
    logic                 tx_full, tx_empty, rx_full, rx_empty;
    logic                 tx_push, tx_pop, rx_push, rx_pop;
    logic                 tx_drop_evt, rx_under_evt, flush, clr_sticky;
    logic [DataWidth-1:0] status, ctrl_rd, rx_head;

    assign bus.Hit = (bus.Address[AddrWidth-1:2] == BaseAddr[AddrWidth-1:2]);
    assign access  = bus.Mem_En & bus.Hit;
    assign cpu_wr  = access & bus.Write_EN;
    assign cpu_rd  = access & ~bus.Write_EN;
    assign offset  = reg_off_e'(bus.Address[1:0]);

    // Full: same slot index, different wrap bit.
    assign tx_full  = (tx_wptr_q ^ tx_rptr_q) == PtrW'(Depth);
    assign tx_empty = (tx_wptr_q == tx_rptr_q);
    assign rx_full  = (rx_wptr_q ^ rx_rptr_q) == PtrW'(Depth);
    assign rx_empty = (rx_wptr_q == rx_rptr_q);

    assign bus.Tx_Data  = tx_mem_q[tx_rptr_q[FifoDepthLog2-1:0]];
    assign bus.Tx_Valid = ~tx_empty;
    assign bus.Rx_Ready = ~rx_full & Reset;
    assign rx_head      = rx_mem_q[rx_rptr_q[FifoDepthLog2-1:0]];

    assign tx_push      = cpu_wr & (offset == OFF_DATA) & ~tx_full;
    assign tx_drop_evt  = cpu_wr & (offset == OFF_DATA) & tx_full;
    assign tx_pop       = bus.Tx_Valid & bus.Tx_Ready;
    assign rx_push      = bus.Rx_Valid & bus.Rx_Ready;
    assign rx_pop       = cpu_rd & (offset == OFF_DATA) & ~rx_empty;
    assign rx_under_evt = cpu_rd & (offset == OFF_DATA) & rx_empty;
    assign flush        = cpu_wr & (offset == OFF_CTRL) & bus.DIn[1];
    assign clr_sticky   = cpu_wr & (offset == OFF_CTRL) & bus.DIn[0];

    assign status = DataWidth'({rx_under_q, tx_drop_q, rx_full, rx_empty, tx_empty, tx_full});

`ifdef IO_RESPONDER_IRQ_EN
    logic [1:0] ctrl_q, ctrl_d;
    logic       irq_q, irq_d;

    always_comb begin
        ctrl_d = ctrl_q;
        if (cpu_wr && offset == OFF_CTRL) ctrl_d = bus.DIn[3:2];
        irq_d = (ctrl_q[0] & ~rx_empty) | (ctrl_q[1] & tx_empty);
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            ctrl_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            ctrl_q <= ctrl_d;
            irq_q  <= irq_d;
        end
    end

    assign ctrl_rd = DataWidth'({ctrl_q, 2'b00});
    assign Irq     = irq_q;
`else
    assign ctrl_rd = '0;
`endif

    // NOTE: every next-state value gets its default before any condition,
    // so no path through this block can leave a signal unassigned (no latch).
    always_comb begin
        tx_wptr_d  = tx_wptr_q + PtrW'(tx_push);
        tx_rptr_d  = tx_rptr_q + PtrW'(tx_pop);
        rx_wptr_d  = rx_wptr_q + PtrW'(rx_push);
        rx_rptr_d  = rx_rptr_q + PtrW'(rx_pop);
        tx_drop_d  = tx_drop_evt | (tx_drop_q & ~clr_sticky);
        rx_under_d = rx_under_evt | (rx_under_q & ~clr_sticky);
        dout_d     = dout_q;

        if (flush) begin
            tx_wptr_d = '0;
            tx_rptr_d = '0;
            rx_wptr_d = '0;
            rx_rptr_d = '0;
        end

        if (cpu_rd) begin
            unique case (offset)
                OFF_DATA:   dout_d = rx_empty ? '0 : rx_head;
                OFF_STATUS: dout_d = status;
                OFF_CTRL:   dout_d = ctrl_rd;
                OFF_RSVD:   dout_d = '0;
                default:    dout_d = '0;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of block evaluation order.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            tx_drop_q  <= 1'b0;
            rx_under_q <= 1'b0;
            dout_q     <= '0;
        end else begin
            tx_wptr_q  <= tx_wptr_d;
            tx_rptr_q  <= tx_rptr_d;
            rx_wptr_q  <= rx_wptr_d;
            rx_rptr_q  <= rx_rptr_d;
            tx_drop_q  <= tx_drop_d;
            rx_under_q <= rx_under_d;
            dout_q     <= dout_d;
        end
    end

    // NOTE: FIFO storage has no reset; entries are only visible between the
    // pointers, and the pointers are reset.
    always_ff @(posedge Clk) begin
        if (tx_push) tx_mem_q[tx_wptr_q[FifoDepthLog2-1:0]] <= bus.DIn;
        if (rx_push) rx_mem_q[rx_wptr_q[FifoDepthLog2-1:0]] <= bus.Rx_Data;
    end

    assign bus.DOut = dout_q;

endmodule

// File: tb/tb_io_responder.sv
// Scoreboard bench for io_responder: stimulus queues expected read data and
// expected TX words; a monitor compares them when the DUT presents them.
module tb_io_responder;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    io_responder_if #(.DataWidth(8), .AddrWidth(8)) bus ();

`ifdef IO_RESPONDER_IRQ_EN
    logic irq;
    io_responder dut (.Clk(clk), .Reset(rst_n), .bus(bus), .Irq(irq));
`else
    io_responder dut (.Clk(clk), .Reset(rst_n), .bus(bus));
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] rd_exp[$];
    logic [7:0] tx_exp[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: sample handshakes at the edge, compare read data half a cycle later.
    initial begin
        logic       rd_fire;
        logic [7:0] got;
        forever begin
            @(posedge clk);
            rd_fire = bus.Mem_En && !bus.Write_EN && (bus.Address[7:2] == 6'h3C) && rst_n;
            if (bus.Tx_Valid && bus.Tx_Ready && rst_n) begin
                got = bus.Tx_Data;
                if (tx_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected: got %0h expected none", got);
                end else check("tx_data", got, tx_exp.pop_front());
            end
            @(negedge clk);
            if (rd_fire) begin
                if (rd_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected: got %0h expected none", bus.DOut);
                end else check("dout", bus.DOut, rd_exp.pop_front());
            end
        end
    end

    task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
        bus.Mem_En = 1'b1; bus.Write_EN = 1'b1; bus.Address = a; bus.DIn = d;
        @(negedge clk);
        bus.Mem_En = 1'b0; bus.Write_EN = 1'b0;
    endtask

    task automatic cpu_read(input logic [7:0] a, input logic [7:0] exp);
        rd_exp.push_back(exp);
        bus.Mem_En = 1'b1; bus.Write_EN = 1'b0; bus.Address = a;
        @(negedge clk);
        bus.Mem_En = 1'b0;
    endtask

    task automatic src_push(input logic [7:0] d);
        bus.Rx_Valid = 1'b1; bus.Rx_Data = d;
        @(negedge clk);
        bus.Rx_Valid = 1'b0;
    endtask

    task automatic drain();
        bus.Tx_Ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!bus.Tx_Valid) break;
        end
        check("tx_drain_done", bus.Tx_Valid, 1'b0);
        bus.Tx_Ready = 1'b0;
    endtask

    initial begin
        bus.Mem_En = 1'b0; bus.Write_EN = 1'b0; bus.Address = 8'h00; bus.DIn = 8'h00;
        bus.Tx_Ready = 1'b0; bus.Rx_Valid = 1'b0; bus.Rx_Data = 8'h00;

        repeat (3) @(negedge clk);
        check("rst_dout", bus.DOut, 8'h00);
        check("rst_tx_valid", bus.Tx_Valid, 1'b0);
        check("rst_rx_ready", bus.Rx_Ready, 1'b0);
        rst_n = 1'b1;
        #1 check("rx_ready_after_rst", bus.Rx_Ready, 1'b1);

        // Window decode edges
        bus.Address = 8'hF0; #1 check("hit_f0", bus.Hit, 1'b1);
        bus.Address = 8'hF3; #1 check("hit_f3", bus.Hit, 1'b1);
        bus.Address = 8'hEF; #1 check("hit_ef", bus.Hit, 1'b0);
        bus.Address = 8'hF4; #1 check("hit_f4", bus.Hit, 1'b0);
        @(negedge clk);

        cpu_read(8'hF1, 8'h06);
        check("tx_valid_idle", bus.Tx_Valid, 1'b0);

        // TX fill, overflow drop, drain in order
        cpu_write(8'hF0, 8'h11); cpu_write(8'hF0, 8'h22);
        cpu_write(8'hF0, 8'h33); cpu_write(8'hF0, 8'h44);
        check("tx_head", bus.Tx_Data, 8'h11);
        cpu_read(8'hF1, 8'h05);
        cpu_write(8'hF0, 8'h55);
        cpu_read(8'hF1, 8'h15);
        tx_exp.push_back(8'h11); tx_exp.push_back(8'h22);
        tx_exp.push_back(8'h33); tx_exp.push_back(8'h44);
        drain();
        cpu_read(8'hF1, 8'h16);

        // RX pops back to back, then underflow
        src_push(8'hA1); src_push(8'hA2);
        cpu_read(8'hF0, 8'hA1); cpu_read(8'hF0, 8'hA2); cpu_read(8'hF0, 8'h00);
        cpu_read(8'hF1, 8'h36);
        cpu_write(8'hF2, 8'h01);
        cpu_read(8'hF1, 8'h06);

        // RX full: offered push refused while CPU pops the oldest
        src_push(8'hB1); src_push(8'hB2); src_push(8'hB3); src_push(8'hB4);
        check("rx_ready_full", bus.Rx_Ready, 1'b0);
        cpu_read(8'hF1, 8'h0A);
        bus.Rx_Valid = 1'b1; bus.Rx_Data = 8'hC5;
        cpu_read(8'hF0, 8'hB1);
        bus.Rx_Valid = 1'b0;
        check("rx_ready_after_pop", bus.Rx_Ready, 1'b1);
        cpu_read(8'hF0, 8'hB2); cpu_read(8'hF0, 8'hB3); cpu_read(8'hF0, 8'hB4);
        cpu_read(8'hF1, 8'h06);

        // Empty-RX read with a same-edge push: read returns 0, word kept
        bus.Rx_Valid = 1'b1; bus.Rx_Data = 8'hD7;
        cpu_read(8'hF0, 8'h00);
        bus.Rx_Valid = 1'b0;
        cpu_read(8'hF0, 8'hD7);
        cpu_read(8'hF1, 8'h26);
        cpu_write(8'hF2, 8'h01);

        // Write to full TX with a same-edge sink pop is still dropped
        cpu_write(8'hF0, 8'h61); cpu_write(8'hF0, 8'h62);
        cpu_write(8'hF0, 8'h63); cpu_write(8'hF0, 8'h64);
        tx_exp.push_back(8'h61); tx_exp.push_back(8'h62);
        tx_exp.push_back(8'h63); tx_exp.push_back(8'h64);
        bus.Tx_Ready = 1'b1;
        cpu_write(8'hF0, 8'h65);
        drain();
        cpu_read(8'hF1, 8'h16);
        cpu_write(8'hF2, 8'h01);

        // Flush on the same edge as a sink pop: both FIFOs end empty
        cpu_read(8'hF0, 8'h00);
        src_push(8'hE1);
        cpu_write(8'hF0, 8'h71); cpu_write(8'hF0, 8'h72);
        tx_exp.push_back(8'h71);
        bus.Tx_Ready = 1'b1;
        cpu_write(8'hF2, 8'h02);
        bus.Tx_Ready = 1'b0;
        check("tx_valid_after_flush", bus.Tx_Valid, 1'b0);
        cpu_read(8'hF1, 8'h26);
        cpu_write(8'hF2, 8'h01);
        cpu_read(8'hF1, 8'h06);

        // Ignored writes and non-hit accesses
        bus.Mem_En = 1'b1; bus.Write_EN = 1'b0; bus.Address = 8'h10;
        @(negedge clk);
        bus.Mem_En = 1'b0;
        check("dout_hold_nonhit", bus.DOut, 8'h06);
        cpu_write(8'hEC, 8'h99); cpu_write(8'hF4, 8'h99);
        cpu_write(8'hF1, 8'hFF); cpu_write(8'hF3, 8'hFF);
        check("tx_valid_nonhit", bus.Tx_Valid, 1'b0);
        cpu_read(8'hF3, 8'h00);
        cpu_read(8'hF1, 8'h06);

`ifdef IO_RESPONDER_IRQ_EN
        cpu_write(8'hF2, 8'h04);
        cpu_read(8'hF2, 8'h04);
        check("irq_idle", irq, 1'b0);
        src_push(8'h5A);
        @(negedge clk);
        check("irq_rx_set", irq, 1'b1);
        cpu_read(8'hF0, 8'h5A);
        check("irq_still_set", irq, 1'b1);
        @(negedge clk);
        check("irq_rx_clear", irq, 1'b0);
        cpu_write(8'hF2, 8'h0C);
        cpu_read(8'hF2, 8'h0C);
`else
        cpu_write(8'hF2, 8'h0C);
        cpu_read(8'hF2, 8'h00);
`endif

        // Reset mid-stream
        cpu_write(8'hF0, 8'h81);
        src_push(8'hF9); src_push(8'hFA);
        cpu_read(8'hF0, 8'hF9);
        check("tx_valid_pre_rst", bus.Tx_Valid, 1'b1);
`ifdef IO_RESPONDER_IRQ_EN
        check("irq_pre_rst", irq, 1'b1);
`endif
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_dout", bus.DOut, 8'h00);
        check("mid_rst_tx_valid", bus.Tx_Valid, 1'b0);
        check("mid_rst_rx_ready", bus.Rx_Ready, 1'b0);
`ifdef IO_RESPONDER_IRQ_EN
        check("mid_rst_irq", irq, 1'b0);
`endif
        rst_n = 1'b1;
        #1 check("rx_ready_release", bus.Rx_Ready, 1'b1);
        @(negedge clk);
        cpu_read(8'hF1, 8'h06);
        cpu_read(8'hF2, 8'h00);
        cpu_read(8'hF0, 8'h00);

        repeat (3) @(negedge clk);
        check("rd_queue_empty", rd_exp.size(), 0);
        check("tx_queue_empty", tx_exp.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
